ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 131 +++++++++++++
 tb/tb_ram_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Loads a byte stream into an external RAM, then streams it back one byte per handshake.
// Optional running checksum of loaded bytes: define RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] len,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] ram_address,
    output logic [7:0] ram_data_in,
    output logic       ram_wr,
    output logic       ram_rd,
    input  logic [7:0] ram_data_out,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum
);

    typedef enum logic [2:0] {IDLE, LOAD, READ, HOLD, DONE} state_t;

    localparam logic [8:0] DEPTH_9  = 9'(DEPTH);
    localparam logic [7:0] LAST_MAX = 8'(DEPTH - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_last;
    logic [7:0] r_wr_cnt;
    logic [7:0] r_rd_cnt;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       w_len_clamp;
    logic [7:0] w_last_eff;
    logic       w_in_xfer;

    // The job length is stored as its last index so DEPTH=256 still fits in 8 bits.
    assign w_len_clamp = (len == 8'd0) || ({1'b0, len} > DEPTH_9);
    assign w_last_eff  = w_len_clamp ? LAST_MAX : (len - 8'd1);
    assign w_in_xfer   = (r_state == LOAD) && in_valid;

    assign ram_data_in = in_data;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;

    // NOTE: asynchronous reset belongs in the sensitivity list; state uses <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        ram_wr       = 1'b0;
        ram_rd       = 1'b0;
        ram_address  = 8'd0;
        busy         = (r_state != IDLE);
        done         = 1'b0;
        case (r_state)
            IDLE: if (start) w_next_state = LOAD;
            LOAD: begin
                in_ready    = 1'b1;
                ram_wr      = in_valid;
                ram_address = r_wr_cnt;
                if (w_in_xfer && (r_wr_cnt == r_last)) w_next_state = READ;
            end
            READ: begin
                ram_rd       = 1'b1;
                ram_address  = r_rd_cnt;
                w_next_state = HOLD;
            end
            HOLD: if (out_ready) w_next_state = (r_rd_cnt == r_last) ? DONE : READ;
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= 8'd0;
            r_wr_cnt    <= 8'd0;
            r_rd_cnt    <= 8'd0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_last   <= w_last_eff;
                    r_wr_cnt <= 8'd0;
                    r_rd_cnt <= 8'd0;
                end
                // Counters stop at the last index so the address never leaves 0..DEPTH-1.
                LOAD: if (w_in_xfer && (r_wr_cnt != r_last)) r_wr_cnt <= r_wr_cnt + 8'd1;
                READ: begin
                    r_out_data  <= ram_data_out;
                    r_out_valid <= 1'b1;
                end
                HOLD: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    if (r_rd_cnt != r_last) r_rd_cnt <= r_rd_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_checksum <= 8'd0;
        else if ((r_state == IDLE) && start)   r_checksum <= 8'd0;
        else if (w_in_xfer)                    r_checksum <= r_checksum + in_data;
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'd0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: a job-level model predicts every output each cycle,
// plus literal expectations for the basic, wrap, clamp, illegal-input and reset scenarios.
module tb_ram_loader;

    localparam int DEPTH = 8;
`ifdef RAM_LOADER_CHECKSUM_EN
    localparam logic [7:0] CK_BASIC = 8'h66;
    localparam logic [7:0] CK_WRAP  = 8'h01;
`else
    localparam logic [7:0] CK_BASIC = 8'h00;
    localparam logic [7:0] CK_WRAP  = 8'h00;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] ram_address;
    logic [7:0] ram_data_in;
    logic       ram_wr;
    logic       ram_rd;
    logic [7:0] ram_data_out;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    ram_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_data_out(ram_data_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream RAM: synchronous write, combinational read.
    logic [7:0] mem [0:255];
    always @(posedge clk) if (ram_wr) mem[ram_address] <= ram_data_in;
    assign ram_data_out = mem[ram_address];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff_len(input logic [7:0] l);
        return ((l == 8'd0) || (int'(l) > DEPTH)) ? DEPTH : int'(l);
    endfunction

    // Job-level model
    logic       m_active = 1'b0;
    int         m_len    = 0;
    int         m_nread  = 0;
    logic [7:0] m_sum    = 8'd0;
    logic [7:0] m_bytes[$];
    logic [7:0] src_q[$];
    int         done_cnt = 0;
    int         wait_cnt = 0;

    // Previous-cycle facts the monitor carries forward
    logic p_load_last = 1'b0, p_hs = 1'b0, p_final = 1'b0, p_rd = 1'b0, p_ov = 1'b0;
    logic [7:0] p_od = 8'd0;

    // Stimulus modes
    int   iv_mode = 0;
    int   or_mode = 0;
    logic junk    = 1'b0;
    logic tgl     = 1'b0;

    always @(posedge clk) begin
        #1;
        tgl = ~tgl;
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
        end else if (src_q.size() != 0) begin
            case (iv_mode)
                0:       in_valid = ($urandom_range(0, 3) != 0);
                1:       in_valid = tgl;
                default: in_valid = 1'b1;
            endcase
            in_data = src_q[0];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        case (or_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = (wait_cnt >= 5);
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        logic exp_in_ready, exp_wr, exp_rd, exp_ov, exp_done, hs;
        logic [7:0] exp_ck;
        if (rst) begin
            check("in_reset", {busy, in_ready, ram_wr, ram_rd, out_valid, done, out_data, checksum}, 0);
            p_load_last = 0; p_hs = 0; p_final = 0; p_rd = 0; p_ov = 0; wait_cnt = 0;
        end else begin
            exp_in_ready = m_active && (m_bytes.size() < m_len);
            exp_wr       = exp_in_ready && in_valid;
            exp_rd       = m_active && (p_load_last || (p_hs && !p_final));
            exp_ov       = m_active && (p_rd || (p_ov && !p_hs));
            exp_done     = m_active && p_final;
`ifdef RAM_LOADER_CHECKSUM_EN
            exp_ck = m_sum;
`else
            exp_ck = 8'd0;
`endif
            check("busy", busy, m_active);
            check("in_ready", in_ready, exp_in_ready);
            check("ram_wr", ram_wr, exp_wr);
            check("ram_rd", ram_rd, exp_rd);
            check("rd_wr_excl", ram_rd & ram_wr, 0);
            check("out_valid", out_valid, exp_ov);
            check("done", done, exp_done);
            check("checksum", checksum, exp_ck);
            if (ram_wr || ram_rd) check("addr_range", int'(ram_address) < DEPTH, 1);
            if (exp_wr) begin
                check("wr_addr", ram_address, m_bytes.size());
                check("wr_data", ram_data_in, in_data);
            end
            if (exp_rd) check("rd_addr", ram_address, m_nread);
            if (exp_ov && (m_nread < m_bytes.size())) begin
                check("out_data", out_data, m_bytes[m_nread]);
                if (p_ov && !p_hs) check("out_stable", out_data, p_od);
            end

            hs = exp_ov && out_ready;
            p_load_last = 1'b0;
            if (exp_wr) begin
                m_bytes.push_back(in_data);
                m_sum = m_sum + in_data;
                if (src_q.size() != 0) void'(src_q.pop_front());
                p_load_last = (m_bytes.size() == m_len);
            end
            p_final = hs && (m_nread + 1 == m_len);
            if (hs) m_nread++;
            if (hs) wait_cnt = 0;
            else if (exp_ov) wait_cnt++;
            p_hs = hs; p_rd = exp_rd; p_ov = exp_ov; p_od = out_data;
            if (done) done_cnt++;
            if (exp_done) m_active = 1'b0;
        end
    end

    task automatic start_job(input logic [7:0] l);
        if (src_q.size() == 0)
            for (int i = 0; i < eff_len(l); i++) src_q.push_back(8'($urandom));
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start    = 1'b0;
        len      = 8'($urandom);
        m_len    = eff_len(l);
        m_bytes.delete();
        m_nread  = 0;
        m_sum    = 8'd0;
        m_active = 1'b1;
    endtask

    task automatic wait_job(input int budget);
        for (int i = 0; (i < budget) && m_active; i++) @(posedge clk);
        check("job_finished", m_active, 0);
        @(negedge clk); #1;
    endtask

    task automatic check_mem_vs_job(input string name);
        for (int k = 0; k < m_bytes.size(); k++) check(name, mem[k], m_bytes[k]);
    endtask

    initial begin
        logic [7:0] snap[0:7];
        logic [7:0] b0, b1;
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        #1;
        check("reset_state", {busy, in_ready, ram_wr, ram_rd, out_valid, done, out_data, checksum}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic job
        d0 = done_cnt;
        src_q = '{8'h11, 8'h22, 8'h33};
        start_job(8'd3);
        wait_job(400);
        check("basic_mem0", mem[0], 8'h11);
        check("basic_mem1", mem[1], 8'h22);
        check("basic_mem2", mem[2], 8'h33);
        check("basic_reads", m_nread, 3);
        check("basic_done_pulses", done_cnt - d0, 1);
        check("basic_cksum", checksum, CK_BASIC);

        // Checksum wrap
        src_q = '{8'hFF, 8'h02};
        start_job(8'd2);
        wait_job(400);
        check("wrap_cksum", checksum, CK_WRAP);

        // Length clamps
        start_job(8'd0);
        wait_job(400);
        check("clamp0_writes", m_bytes.size(), 8);
        check("clamp0_reads", m_nread, 8);
        check_mem_vs_job("clamp0_mem");
        start_job(8'd20);
        wait_job(400);
        check("clamp20_writes", m_bytes.size(), 8);
        check("clamp20_reads", m_nread, 8);
        check_mem_vs_job("clamp20_mem");

        // Backpressure and input stalls
        iv_mode = 1; or_mode = 1;
        start_job(8'd5);
        wait_job(600);
        check("bp_reads", m_nread, 5);
        check_mem_vs_job("bp_mem");

        // start during LOAD is ignored
        start_job(8'd4);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; len = 8'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_job(600);
        check("ign_start_writes", m_bytes.size(), 4);
        check("ign_start_reads", m_nread, 4);

        // in_valid during IDLE writes nothing
        iv_mode = 0; or_mode = 0;
        for (int k = 0; k < 8; k++) snap[k] = mem[k];
        d0 = done_cnt;
        junk = 1'b1;
        repeat (6) @(posedge clk);
        #2 junk = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 8; k++) check("idle_junk_mem", mem[k], snap[k]);
        check("idle_junk_done", done_cnt - d0, 0);

        // Reset mid-job after 2 of 4 bytes
        iv_mode = 2;
        start_job(8'd4);
        for (int i = 0; (i < 100) && (m_bytes.size() < 2); i++) @(posedge clk);
        check("midrst_two_loaded", m_bytes.size(), 2);
        for (int k = 0; k < 8; k++) snap[k] = mem[k];
        b0 = m_bytes[0]; b1 = m_bytes[1];
        #3;
        rst = 1'b1;
        m_active = 1'b0; src_q.delete(); junk = 1'b1; m_sum = 8'd0;
        #1;
        check("midrst_outputs", {busy, in_ready, ram_wr, ram_rd, out_valid, done, out_data, checksum}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 junk = 1'b0;
        @(negedge clk);
        check("midrst_mem0", mem[0], b0);
        check("midrst_mem1", mem[1], b1);
        for (int k = 2; k < 8; k++) check("midrst_mem_kept", mem[k], snap[k]);
        start_job(8'd2);
        wait_job(400);
        check("midrst_new_reads", m_nread, 2);
        check_mem_vs_job("midrst_new_mem");

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            logic [7:0] l;
            iv_mode = $urandom_range(0, 2);
            or_mode = $urandom_range(0, 2);
            l = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            start_job(l);
            wait_job(800);
            check("rand_reads", m_nread, eff_len(l));
            check_mem_vs_job("rand_mem");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
